// File: rtl/knight_cmd_assembler.sv
// Bridge between the BLE UART and the KnightsTour command logic: frames byte pairs
// into 16-bit commands and serializes 8-bit responses through a one-deep pending buffer.
module knight_cmd_assembler #(
  parameter int TIMEOUT = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  output logic        frame_err,
  input  logic [7:0]  resp,
  input  logic        snd_resp,
  output logic        trmt,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  output logic        resp_busy,
  output logic        resp_drop
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT_LO = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;

  logic [1:0]       r_state;
  logic [7:0]       r_hi_byte;
  logic [CNT_W-1:0] r_cnt;
  logic             r_clr_rx_rdy;
  logic [15:0]      r_cmd;
  logic             r_cmd_rdy;
  logic             r_frame_err;

  logic             r_busy;
  logic             r_trmt;
  logic [7:0]       r_tx_data;
  logic             r_pend_valid;
  logic [7:0]       r_pend_data;
  logic             r_drop;

  logic             w_accept;

  // The registered acknowledge masks the still-high rx_rdy for one cycle, so a byte
  // is never captured twice; HOLD applies backpressure by refusing every byte.
  assign w_accept = rx_rdy && !r_clr_rx_rdy && (r_state != ST_HOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_hi_byte    <= 8'h00;
      r_cnt        <= '0;
      r_clr_rx_rdy <= 1'b0;
      r_cmd        <= 16'h0000;
      r_cmd_rdy    <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_clr_rx_rdy <= w_accept;
      r_frame_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_hi_byte <= rx_data;
            r_cnt     <= '0;
            r_state   <= ST_WAIT_LO;
          end
        end
        ST_WAIT_LO: begin
          // A byte arriving on the timeout cycle still completes the frame.
          if (w_accept) begin
            r_cmd     <= {r_hi_byte, rx_data};
            r_cmd_rdy <= 1'b1;
            r_state   <= ST_HOLD;
          end else if (r_cnt == CNT_LAST) begin
            r_frame_err <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (clr_cmd_rdy) begin
            r_cmd_rdy <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy       <= 1'b0;
      r_trmt       <= 1'b0;
      r_tx_data    <= 8'h00;
      r_pend_valid <= 1'b0;
      r_pend_data  <= 8'h00;
      r_drop       <= 1'b0;
    end else begin
      r_trmt <= 1'b0;
      r_drop <= 1'b0;
      if (!r_busy) begin
        if (snd_resp) begin
          r_tx_data <= resp;
          r_trmt    <= 1'b1;
          r_busy    <= 1'b1;
        end
      end else if (tx_done) begin
        // Chain the next byte straight away so resp_busy never drops between bytes.
        if (r_pend_valid) begin
          r_tx_data <= r_pend_data;
          r_trmt    <= 1'b1;
          if (snd_resp) begin
            r_pend_data <= resp;
          end else begin
            r_pend_valid <= 1'b0;
          end
        end else if (snd_resp) begin
          r_tx_data <= resp;
          r_trmt    <= 1'b1;
        end else begin
          r_busy <= 1'b0;
        end
      end else if (snd_resp) begin
        if (!r_pend_valid) begin
          r_pend_data  <= resp;
          r_pend_valid <= 1'b1;
        end else begin
          r_drop <= 1'b1;
        end
      end
    end
  end

  assign clr_rx_rdy = r_clr_rx_rdy;
  assign cmd        = r_cmd;
  assign cmd_rdy    = r_cmd_rdy;
  assign frame_err  = r_frame_err;
  assign trmt       = r_trmt;
  assign tx_data    = r_tx_data;
  assign resp_busy  = r_busy;
  assign resp_drop  = r_drop;

endmodule

// File: tb/tb_knight_cmd_assembler.sv
// Directed bench for knight_cmd_assembler: command framing, timeout, backpressure,
// response serialization and asynchronous reset, all with hand-computed expectations.
module tb_knight_cmd_assembler;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        frame_err;
  logic [7:0]  resp;
  logic        snd_resp;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        resp_busy;
  logic        resp_drop;

  int checks = 0;
  int failures = 0;
  int fe_cnt = 0;

  knight_cmd_assembler #(.TIMEOUT(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_rdy      (rx_rdy),
    .rx_data     (rx_data),
    .clr_rx_rdy  (clr_rx_rdy),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .frame_err   (frame_err),
    .resp        (resp),
    .snd_resp    (snd_resp),
    .trmt        (trmt),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .resp_busy   (resp_busy),
    .resp_drop   (resp_drop)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err) fe_cnt <= fe_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Behaves like the UART receiver: holds rx_rdy until acknowledged.
  task automatic send_byte(input logic [7:0] b);
    int waited;
    rx_data = b;
    rx_rdy  = 1'b1;
    waited  = 0;
    do begin
      tick();
      waited++;
    end while (!clr_rx_rdy && waited < 100);
    check_eq("rx_ack_seen", {31'd0, clr_rx_rdy}, 32'd1);
    rx_rdy = 1'b0;
    tick();
    check_eq("rx_ack_single", {31'd0, clr_rx_rdy}, 32'd0);
  endtask

  task automatic clear_cmd();
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    check_eq("cmd_rdy_cleared", {31'd0, cmd_rdy}, 32'd0);
  endtask

  initial begin
    int fe_base;
    int first_fe;
    rst = 1'b1; rx_rdy = 1'b0; rx_data = 8'h00; clr_cmd_rdy = 1'b0;
    resp = 8'h00; snd_resp = 1'b0; tx_done = 1'b0;
    tick();
    check_eq("rst_cmd", {16'd0, cmd}, 32'h0000);
    check_eq("rst_flags", {26'd0, cmd_rdy, clr_rx_rdy, frame_err, trmt, resp_busy, resp_drop}, 32'd0);
    check_eq("rst_tx_data", {24'd0, tx_data}, 32'h00);
    rst = 1'b0;
    tick();

    // MOVE frame
    send_byte(8'h23);
    send_byte(8'hF1);
    check_eq("move_cmd", {16'd0, cmd}, 32'h23F1);
    check_eq("move_rdy", {31'd0, cmd_rdy}, 32'd1);
    clear_cmd();
    check_eq("move_cmd_kept", {16'd0, cmd}, 32'h23F1);

    // CALIBRATE then TOUR
    fe_base = fe_cnt;
    send_byte(8'h00);
    send_byte(8'h00);
    check_eq("cal_cmd", {16'd0, cmd}, 32'h0000);
    repeat (3) tick();
    check_eq("cal_rdy_held", {31'd0, cmd_rdy}, 32'd1);
    clear_cmd();
    send_byte(8'h40);
    send_byte(8'h22);
    check_eq("tour_cmd", {16'd0, cmd}, 32'h4022);
    repeat (3) tick();
    check_eq("tour_rdy_held", {31'd0, cmd_rdy}, 32'd1);
    clear_cmd();
    check_eq("cal_tour_no_ferr", fe_cnt - fe_base, 32'd0);

    // Timeout: frame_err lands 15 ticks after send_byte returns (16 waiting clocks)
    fe_base  = fe_cnt;
    first_fe = 0;
    send_byte(8'h40);
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (frame_err && first_fe == 0) first_fe = i;
    end
    check_eq("timeout_pulses", fe_cnt - fe_base, 32'd1);
    check_eq("timeout_cycle", first_fe, 32'd15);
    check_eq("timeout_cmd_kept", {16'd0, cmd}, 32'h4022);
    check_eq("timeout_no_rdy", {31'd0, cmd_rdy}, 32'd0);
    send_byte(8'h40);
    send_byte(8'h22);
    check_eq("after_to_cmd", {16'd0, cmd}, 32'h4022);
    check_eq("after_to_rdy", {31'd0, cmd_rdy}, 32'd1);

    // Backpressure while cmd_rdy is held
    rx_data = 8'h55;
    rx_rdy  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("bp_no_ack", {31'd0, clr_rx_rdy}, 32'd0);
    end
    clear_cmd();
    check_eq("bp_ack_after_clr", {31'd0, clr_rx_rdy}, 32'd0);
    tick();
    check_eq("bp_hi_accepted", {31'd0, clr_rx_rdy}, 32'd1);
    rx_rdy  = 1'b0;
    fe_base = fe_cnt;
    repeat (15) tick();
    send_byte(8'h22);
    repeat (4) tick();
    check_eq("edge_no_ferr", fe_cnt - fe_base, 32'd0);
    check_eq("edge_cmd", {16'd0, cmd}, 32'h5522);
    check_eq("edge_rdy", {31'd0, cmd_rdy}, 32'd1);
    clear_cmd();

    // Responses: 0x5A, 0xA5 pending, 0x77 dropped
    resp = 8'h5A; snd_resp = 1'b1;
    tick();
    snd_resp = 1'b0;
    check_eq("r1_trmt", {31'd0, trmt}, 32'd1);
    check_eq("r1_data", {24'd0, tx_data}, 32'h5A);
    check_eq("r1_busy", {31'd0, resp_busy}, 32'd1);
    tick();
    check_eq("r1_trmt_pulse", {31'd0, trmt}, 32'd0);
    resp = 8'hA5; snd_resp = 1'b1;
    tick();
    snd_resp = 1'b0;
    check_eq("r2_pend_no_drop", {30'd0, trmt, resp_drop}, 32'd0);
    check_eq("r2_data_stable", {24'd0, tx_data}, 32'h5A);
    resp = 8'h77; snd_resp = 1'b1;
    tick();
    snd_resp = 1'b0;
    check_eq("r3_drop", {31'd0, resp_drop}, 32'd1);
    tick();
    check_eq("r3_drop_pulse", {31'd0, resp_drop}, 32'd0);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check_eq("r2_trmt", {31'd0, trmt}, 32'd1);
    check_eq("r2_data", {24'd0, tx_data}, 32'hA5);
    check_eq("r2_busy_cont", {31'd0, resp_busy}, 32'd1);
    tick();
    check_eq("r2_busy_hold", {30'd0, resp_busy, trmt}, 32'd2);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check_eq("r_idle_busy", {31'd0, resp_busy}, 32'd0);
    check_eq("r_idle_trmt", {31'd0, trmt}, 32'd0);

    // tx_done and snd_resp together with pending full
    resp = 8'h11; snd_resp = 1'b1;
    tick();
    resp = 8'h22;
    tick();
    resp = 8'h33; tx_done = 1'b1;
    tick();
    snd_resp = 1'b0; tx_done = 1'b0;
    check_eq("sc_data", {24'd0, tx_data}, 32'h22);
    check_eq("sc_trmt_nodrop", {30'd0, trmt, resp_drop}, 32'd2);
    tx_done = 1'b1;
    tick();
    check_eq("sc_next_data", {24'd0, tx_data}, 32'h33);
    tick();
    tx_done = 1'b0;
    check_eq("sc_done_busy", {31'd0, resp_busy}, 32'd0);

    // tx_done and snd_resp together with pending empty
    resp = 8'h44; snd_resp = 1'b1;
    tick();
    resp = 8'h66; tx_done = 1'b1;
    tick();
    snd_resp = 1'b0; tx_done = 1'b0;
    check_eq("se_data", {24'd0, tx_data}, 32'h66);
    check_eq("se_trmt_busy", {29'd0, trmt, resp_busy, resp_drop}, 32'd6);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;

    // Reset mid-frame and mid-transmission
    resp = 8'h5A; snd_resp = 1'b1;
    tick();
    snd_resp = 1'b0;
    send_byte(8'h23);
    rst = 1'b1;
    #1;
    check_eq("arst_cmd", {16'd0, cmd}, 32'h0000);
    check_eq("arst_flags", {26'd0, cmd_rdy, clr_rx_rdy, frame_err, trmt, resp_busy, resp_drop}, 32'd0);
    check_eq("arst_tx_data", {24'd0, tx_data}, 32'h00);
    tick();
    rst = 1'b0;
    tick();
    send_byte(8'h40);
    send_byte(8'h22);
    check_eq("post_rst_cmd", {16'd0, cmd}, 32'h4022);
    check_eq("post_rst_rdy", {31'd0, cmd_rdy}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
